mb_scan_ctrl: RTL and testbench

MB_SCAN_CTRL -- requirements
Module: mb_scan_ctrl

---
 rtl/h264_scan_pkg.sv | 23 ++
 rtl/mb_coord_counter.sv | 40 ++++
 rtl/mb_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_mb_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/h264_scan_pkg.sv
// Shared types and geometry for the macroblock scan controller.
// Coordinates are luma pixels; MB indices count 16x16 macroblocks.
package h264_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_MB = 2'd2,
        ST_DONE    = 2'd3
    } scan_state_t;

    localparam int MB_SIZE  = 16;
    localparam int BLK_SIZE = 4;
    localparam int COORD_W  = 9;
    localparam int MB_IDX_W = 5;

    // Pixel coordinate of a 4x4 block's corner along one axis.
    function automatic logic [COORD_W-1:0] blk_coord(input logic [MB_IDX_W-1:0] mb,
                                                     input logic [1:0]          sub);
        return COORD_W'(mb) * COORD_W'(MB_SIZE) + COORD_W'(sub) * COORD_W'(BLK_SIZE);
    endfunction

endpackage

// File: rtl/mb_coord_counter.sv
// Macroblock column/row counter, raster order; clear and advance take effect next cycle.
// No backpressure: advance is a one-cycle command from the scan FSM.
module mb_coord_counter
    import h264_scan_pkg::*;
#(
    parameter int MB_COLS = 22,
    parameter int MB_ROWS = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                advance,
    output logic [MB_IDX_W-1:0] mb_x,
    output logic [MB_IDX_W-1:0] mb_y,
    output logic                mb_first,
    output logic                last_col,
    output logic                last_mb
);

    logic [MB_IDX_W-1:0] nxt_x;
    logic [MB_IDX_W-1:0] nxt_y;

    assign last_col = (mb_x == MB_IDX_W'(MB_COLS - 1));
    assign last_mb  = last_col && (mb_y == MB_IDX_W'(MB_ROWS - 1));
    assign nxt_x    = last_col ? '0 : mb_x + MB_IDX_W'(1);
    assign nxt_y    = last_col ? mb_y + MB_IDX_W'(1) : mb_y;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            mb_x     <= '0;
            mb_y     <= '0;
            mb_first <= 1'b1;
        end else if (advance) begin
            mb_x     <= nxt_x;
            mb_y     <= nxt_y;
            mb_first <= (nxt_x == '0) && (nxt_y == '0);
        end
    end

endmodule

// File: rtl/mb_scan_ctrl.sv
// Frame scan: 16 raster-ordered 4x4 fetch requests per MB, then waits for mb_ack; outputs registered.
// Fetch port is valid/ready: req_x/req_y hold while stalled; abort drops to IDLE in one cycle.
module mb_scan_ctrl
    import h264_scan_pkg::*;
#(
    parameter int WIDTH  = 352,
    parameter int HEIGHT = 288
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                req_ready,
    input  logic                mb_ack,
    output logic                req_valid,
    output logic [COORD_W-1:0]  req_x,
    output logic [COORD_W-1:0]  req_y,
    output logic [MB_IDX_W-1:0] mb_x,
    output logic [MB_IDX_W-1:0] mb_y,
    output logic                mb_first,
    output logic                mb_issued,
    output logic                busy,
    output logic                done
);

    localparam int MB_COLS = WIDTH / MB_SIZE;
    localparam int MB_ROWS = HEIGHT / MB_SIZE;

    scan_state_t         state_q, state_d;
    logic [3:0]          blk_q, blk_d, blk_inc;
    logic                cnt_clear, cnt_advance;
    logic                last_col, last_mb;
    logic                xfer;
    logic [MB_IDX_W-1:0] adv_x, adv_y;
    logic                req_valid_d, mb_issued_d, done_d;
    logic [COORD_W-1:0]  req_x_d, req_y_d;

    mb_coord_counter #(
        .MB_COLS (MB_COLS),
        .MB_ROWS (MB_ROWS)
    ) u_coord (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .advance  (cnt_advance),
        .mb_x     (mb_x),
        .mb_y     (mb_y),
        .mb_first (mb_first),
        .last_col (last_col),
        .last_mb  (last_mb)
    );

    assign xfer    = req_valid && req_ready;
    assign blk_inc = blk_q + 4'd1;
    // Coordinates of the MB the counter moves to on advance, so the first
    // request of the next MB is registered in the same cycle as the move.
    assign adv_x   = last_col ? '0 : mb_x + MB_IDX_W'(1);
    assign adv_y   = last_col ? mb_y + MB_IDX_W'(1) : mb_y;

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        req_valid_d = 1'b0;
        mb_issued_d = 1'b0;
        done_d      = 1'b0;
        req_x_d     = req_x;
        req_y_d     = req_y;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = ST_ISSUE;
                    blk_d       = '0;
                    cnt_clear   = 1'b1;
                    req_valid_d = 1'b1;
                    req_x_d     = '0;
                    req_y_d     = '0;
                end
            end
            ST_ISSUE: begin
                req_valid_d = 1'b1;
                if (xfer) begin
                    if (blk_q == 4'd15) begin
                        state_d     = ST_WAIT_MB;
                        blk_d       = '0;
                        req_valid_d = 1'b0;
                        mb_issued_d = 1'b1;
                    end else begin
                        blk_d   = blk_inc;
                        req_x_d = blk_coord(mb_x, blk_inc[1:0]);
                        req_y_d = blk_coord(mb_y, blk_inc[3:2]);
                    end
                end
            end
            ST_WAIT_MB: begin
                if (mb_ack) begin
                    if (last_mb) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_ISSUE;
                        cnt_advance = 1'b1;
                        req_valid_d = 1'b1;
                        req_x_d     = blk_coord(adv_x, 2'd0);
                        req_y_d     = blk_coord(adv_y, 2'd0);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A transfer coinciding with abort has left the port but is not counted.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            blk_d       = '0;
            cnt_clear   = 1'b0;
            cnt_advance = 1'b0;
            req_valid_d = 1'b0;
            mb_issued_d = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            blk_q     <= '0;
            req_valid <= 1'b0;
            req_x     <= '0;
            req_y     <= '0;
            mb_issued <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_q     <= blk_d;
            req_valid <= req_valid_d;
            req_x     <= req_x_d;
            req_y     <= req_y_d;
            mb_issued <= mb_issued_d;
            busy      <= (state_d != ST_IDLE);
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_mb_scan_ctrl.sv
// Scoreboarded bench: a 32x32 instance for directed frame/abort/reset cases and a default
// 352x288 instance with a randomly stalling fetch port.
module tb_mb_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_reset, s_start, s_abort, s_ready, s_ack;
    logic       s_req_valid, s_mb_first, s_mb_issued, s_busy, s_done;
    logic [8:0] s_req_x, s_req_y;
    logic [4:0] s_mb_x, s_mb_y;

    logic       d_reset, d_start, d_abort, d_ready, d_ack;
    logic       d_req_valid, d_mb_first, d_mb_issued, d_busy, d_done;
    logic [8:0] d_req_x, d_req_y;
    logic [4:0] d_mb_x, d_mb_y;

    mb_scan_ctrl #(.WIDTH(32), .HEIGHT(32)) dut_s (
        .clk(clk), .reset(s_reset), .start(s_start), .abort(s_abort),
        .req_ready(s_ready), .mb_ack(s_ack), .req_valid(s_req_valid),
        .req_x(s_req_x), .req_y(s_req_y), .mb_x(s_mb_x), .mb_y(s_mb_y),
        .mb_first(s_mb_first), .mb_issued(s_mb_issued), .busy(s_busy), .done(s_done)
    );

    mb_scan_ctrl dut_d (
        .clk(clk), .reset(d_reset), .start(d_start), .abort(d_abort),
        .req_ready(d_ready), .mb_ack(d_ack), .req_valid(d_req_valid),
        .req_x(d_req_x), .req_y(d_req_y), .mb_x(d_mb_x), .mb_y(d_mb_y),
        .mb_first(d_mb_first), .mb_issued(d_mb_issued), .busy(d_busy), .done(d_done)
    );

    int checks   = 0;
    int failures = 0;

    logic [17:0] s_q[$];
    logic [17:0] d_q[$];
    logic [17:0] s_hist[$];
    int s_xfer = 0, s_iss = 0, s_dn = 0;
    int d_xfer = 0, d_iss = 0, d_dn = 0;
    logic [8:0] d_last_x = '0, d_last_y = '0;
    logic [8:0] d_px = '0, d_py = '0;
    logic       d_stall_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [17:0] coord(input int mbx, input int mby, input int b);
        logic [8:0] x, y;
        x = 9'(mbx * 16 + (b % 4) * 4);
        y = 9'(mby * 16 + (b / 4) * 4);
        return {x, y};
    endfunction

    task automatic push_s(input int mbx, input int mby, input int nblk);
        for (int b = 0; b < nblk; b++) s_q.push_back(coord(mbx, mby, b));
    endtask

    task automatic mon_s();
        logic [17:0] e;
        if (!s_reset && s_req_valid && s_ready) begin
            s_hist.push_back({s_req_x, s_req_y});
            s_xfer++;
            if (s_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL s_unexpected_req actual=(%0d,%0d) required=none", s_req_x, s_req_y);
            end else begin
                e = s_q.pop_front();
                chk("s_req_x", int'(s_req_x), int'(e[17:9]));
                chk("s_req_y", int'(s_req_y), int'(e[8:0]));
            end
        end
        if (s_mb_issued) s_iss++;
        if (s_done) s_dn++;
    endtask

    task automatic mon_d();
        logic [17:0] e;
        if (!d_reset) begin
            if (d_stall_prev) begin
                chk("d_stall_valid", int'(d_req_valid), 1);
                chk("d_stall_x", int'(d_req_x), int'(d_px));
                chk("d_stall_y", int'(d_req_y), int'(d_py));
            end
            if (d_req_valid && d_ready) begin
                d_xfer++;
                d_last_x = d_req_x;
                d_last_y = d_req_y;
                if (d_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d_unexpected_req actual=(%0d,%0d) required=none", d_req_x, d_req_y);
                end else begin
                    e = d_q.pop_front();
                    chk("d_req_x", int'(d_req_x), int'(e[17:9]));
                    chk("d_req_y", int'(d_req_y), int'(e[8:0]));
                end
            end
            d_stall_prev = d_req_valid && !d_ready;
            d_px = d_req_x;
            d_py = d_req_y;
            if (d_mb_issued) d_iss++;
            if (d_done) d_dn++;
        end
    endtask

    task automatic chk_s_reset(input string p);
        chk({p, "_req_valid"}, int'(s_req_valid), 0);
        chk({p, "_req_x"},     int'(s_req_x), 0);
        chk({p, "_req_y"},     int'(s_req_y), 0);
        chk({p, "_mb_x"},      int'(s_mb_x), 0);
        chk({p, "_mb_y"},      int'(s_mb_y), 0);
        chk({p, "_mb_first"},  int'(s_mb_first), 1);
        chk({p, "_mb_issued"}, int'(s_mb_issued), 0);
        chk({p, "_busy"},      int'(s_busy), 0);
        chk({p, "_done"},      int'(s_done), 0);
    endtask

    task automatic pulse_s_start();
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
    endtask

    task automatic wait_s_issued(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (s_mb_issued) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=no_mb_issued required=mb_issued", name);
        end
    endtask

    // mb_ack is raised two cycles after the mb_issued pulse, for one cycle.
    task automatic ack_s(input string name);
        wait_s_issued(name);
        @(posedge clk);
        @(posedge clk); #1 s_ack = 1'b1;
        @(posedge clk); #1 s_ack = 1'b0;
    endtask

    initial begin
        int  n, base_iss, base_dn, base_x, cd;
        bit  got;
        s_reset = 1'b1; s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b1; s_ack = 1'b0;
        d_reset = 1'b1; d_start = 1'b0; d_abort = 1'b0; d_ready = 1'b0; d_ack = 1'b0;

        fork
            forever begin @(negedge clk); mon_s(); end
            forever begin @(negedge clk); mon_d(); end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_s_reset("rst");
        @(posedge clk); #1 s_reset = 1'b0; d_reset = 1'b0;

        // Abort on the 7th transfer of MB 2, i.e. MB (0,1).
        push_s(0, 0, 16); push_s(1, 0, 16); push_s(0, 1, 7);
        base_iss = s_iss; base_dn = s_dn;
        pulse_s_start();
        ack_s("abt_mb0");
        ack_s("abt_mb1");
        n = 0;
        for (int i = 0; i < 100 && n < 7; i++) begin
            @(negedge clk);
            if (s_req_valid && s_ready) n++;
        end
        chk("abt_xfers_before", n, 7);
        s_abort = 1'b1;
        @(posedge clk); #1 s_abort = 1'b0;
        @(negedge clk);
        chk("abt_req_valid", int'(s_req_valid), 0);
        chk("abt_busy", int'(s_busy), 0);
        chk("abt_mb_issued", int'(s_mb_issued), 0);
        repeat (5) @(negedge clk);
        chk("abt_done_pulses", s_dn - base_dn, 0);
        chk("abt_issued_pulses", s_iss - base_iss, 2);
        chk("abt_queue_left", s_q.size(), 0);
        chk("abt_idle_valid", int'(s_req_valid), 0);

        // Full 32x32 frame after the abort: restarts at (0,0); stray start/ack during ISSUE.
        for (int mby = 0; mby < 2; mby++)
            for (int mbx = 0; mbx < 2; mbx++) push_s(mbx, mby, 16);
        base_iss = s_iss; base_dn = s_dn; base_x = s_xfer;
        pulse_s_start();
        @(negedge clk);
        chk("frm_first_mb_first", int'(s_mb_first), 1);
        @(posedge clk); #1 s_start = 1'b1; s_ack = 1'b1;
        @(posedge clk); #1 s_start = 1'b0; s_ack = 1'b0;
        ack_s("frm_mb0");
        ack_s("frm_mb1");
        @(negedge clk);
        chk("wrap_mb_x", int'(s_mb_x), 0);
        chk("wrap_mb_y", int'(s_mb_y), 1);
        chk("wrap_req_valid", int'(s_req_valid), 1);
        chk("wrap_req_x", int'(s_req_x), 0);
        chk("wrap_req_y", int'(s_req_y), 16);
        chk("wrap_mb_first", int'(s_mb_first), 0);
        ack_s("frm_mb2");
        ack_s("frm_mb3");
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (s_done) got = 1'b1;
        end
        chk("frm_done_seen", int'(got), 1);
        repeat (4) @(negedge clk);
        chk("frm_done_pulses", s_dn - base_dn, 1);
        chk("frm_issued_pulses", s_iss - base_iss, 4);
        chk("frm_transfers", s_xfer - base_x, 64);
        chk("frm_busy_after", int'(s_busy), 0);
        chk("frm_queue_left", s_q.size(), 0);
        if (s_hist.size() >= base_x + 64) begin
            chk("frm_mb1_first_x", int'(s_hist[base_x + 16][17:9]), 16);
            chk("frm_mb1_first_y", int'(s_hist[base_x + 16][8:0]), 0);
            chk("frm_last_x", int'(s_hist[base_x + 63][17:9]), 28);
            chk("frm_last_y", int'(s_hist[base_x + 63][8:0]), 28);
        end else begin
            checks++;
            failures++;
            $display("FAIL frm_history actual=%0d required=%0d", s_hist.size(), base_x + 64);
        end

        // Reset together with mb_ack while in WAIT_MB.
        push_s(0, 0, 16);
        pulse_s_start();
        wait_s_issued("rst_iss");
        s_reset = 1'b1; s_ack = 1'b1;
        @(posedge clk); #1 s_reset = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        chk_s_reset("midrst");
        repeat (3) @(negedge clk);
        chk("midrst_busy_later", int'(s_busy), 0);
        chk("midrst_queue_left", s_q.size(), 0);

        // Default 352x288 frame with a 50% random ready.
        for (int mby = 0; mby < 18; mby++)
            for (int mbx = 0; mbx < 22; mbx++)
                for (int b = 0; b < 16; b++) d_q.push_back(coord(mbx, mby, b));
        @(posedge clk); #1 d_start = 1'b1;
        @(posedge clk); #1 d_start = 1'b0;
        cd = 0;
        got = 1'b0;
        for (int i = 0; i < 40000 && !got; i++) begin
            @(posedge clk); #1;
            d_ready = ($urandom_range(0, 1) != 0);
            d_ack = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) d_ack = 1'b1;
            end
            if (d_mb_issued) cd = 2;
            if (d_done) got = 1'b1;
        end
        d_ready = 1'b0;
        chk("dflt_done_seen", int'(got), 1);
        repeat (4) @(negedge clk);
        chk("dflt_transfers", d_xfer, 6336);
        chk("dflt_issued_pulses", d_iss, 396);
        chk("dflt_done_pulses", d_dn, 1);
        chk("dflt_last_x", int'(d_last_x), 348);
        chk("dflt_last_y", int'(d_last_y), 284);
        chk("dflt_queue_left", d_q.size(), 0);
        chk("dflt_busy_after", int'(d_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
